serial_rx_fifo: RTL and testbench

// Parametrised single-clock successor to the Deserializer: oversampling receiver for the idle-high serial

---
 rtl/deser_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 88 ++++++++
 rtl/serial_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_serial_rx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the oversampling serial receiver:
//   - rx_state_t     : receiver FSM state encoding
//   - PARITY_*       : parity mode constants (value of the PARITY parameter)
//   - parity_ok()    : checks a received parity bit against the data bits
// ----------------------------------------------------------------------------
package deser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // data_xor is the XOR-reduction of the data bits. The total number of ones
   // over data plus parity bit must be even (EVEN) or odd (ODD).
   function automatic logic parity_ok(input logic data_xor,
                                      input logic parity_bit,
                                      input int   mode);
      logic ones_odd;
      ones_odd = data_xor ^ parity_bit;
      if (mode == PARITY_ODD) begin
         return ones_odd;
      end
      return ~ones_odd;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read port.
//   clk       in   clock
//   rst       in   asynchronous active-high reset (pointers, count, read port)
//   push      in   write request; accepted only when push_ready
//   wr_data   in   WIDTH write data
//   pop       in   read request; ignored when empty
//   rd_data   out  WIDTH registered read data, holds between pops
//   rd_valid  out  1 for the cycle after an accepted pop
//   push_ready out room for a push this cycle, taking a same-cycle pop into account
//   empty     out  no entries stored
//   count     out  occupancy, $clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     push_ready,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      occ_after_pop;
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop        = pop & (count_reg != '0);
   // A push into a full FIFO succeeds when the same cycle also pops.
   assign occ_after_pop = count_reg - {{AW{1'b0}}, do_pop};
   assign push_ready    = (occ_after_pop != DEPTH_C);
   assign do_push       = push & push_ready;

   // Storage has no reset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
   // modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= do_pop;
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg  <= rd_ptr_reg + AW'(1);
            rd_data_reg <= mem[rd_ptr_reg];
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign empty    = (count_reg == '0);
   assign count    = count_reg;

endmodule

// File: rtl/serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// serial_rx_fifo
// Oversampling receiver for an idle-high serial line (start 0, PKT_W data
// bits, optional parity, STOP_BITS stop bits of 1) feeding a FIFO.
//   clock        in   sole clock
//   reset        in   asynchronous active-high reset
//   io_sIn       in   serial line, asynchronous to clock
//   io_rdEn      in   pop request
//   io_clrErr    in   clears the sticky error flags
//   io_dataReady out  FIFO non-empty
//   io_pOut      out  PKT_W registered read data
//   io_validOut  out  io_pOut holds a word popped on the previous edge
//   io_count     out  FIFO occupancy
//   io_frameErr  out  sticky: a stop bit was sampled 0
//   io_parityErr out  sticky: parity mismatch
//   io_overflow  out  sticky: a good frame arrived while the FIFO was full
// ----------------------------------------------------------------------------
module serial_rx_fifo
   import deser_pkg::*;
#(
   parameter int PKT_W        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         io_sIn,
   input  logic                         io_rdEn,
   input  logic                         io_clrErr,
   output logic                         io_dataReady,
   output logic [PKT_W-1:0]             io_pOut,
   output logic                         io_validOut,
   output logic [$clog2(FIFO_DEPTH):0]  io_count,
   output logic                         io_frameErr,
   output logic                         io_parityErr,
   output logic                         io_overflow
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int IDX_W = $clog2(PKT_W) + 1;

   // ---------------------------------------------------------------------
   // Input synchronizer. All three flops reset to 0 so a line that is
   // already low when reset releases never looks like a falling edge.
   // ---------------------------------------------------------------------
   logic sync_1_reg;
   logic sync_2_reg;
   logic line_prev_reg;
   logic line_cur;
   logic start_edge;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1_reg    <= 1'b0;
         sync_2_reg    <= 1'b0;
         line_prev_reg <= 1'b0;
      end else begin
         sync_1_reg    <= io_sIn;
         sync_2_reg    <= sync_1_reg;
         line_prev_reg <= sync_2_reg;
      end
   end

   assign line_cur   = sync_2_reg;
   assign start_edge = line_prev_reg & ~line_cur;

   // ---------------------------------------------------------------------
   // Receiver FSM and datapath
   // ---------------------------------------------------------------------
   rx_state_t         state_reg;
   rx_state_t         state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [IDX_W-1:0]  bit_idx_reg;
   logic [PKT_W-1:0]  shift_reg;
   logic              parity_bit_reg;
   logic              stop_bad_reg;
   logic              bit_tick;
   logic              last_data;
   logic              last_stop;
   logic [IDX_W-1:0]  data_pos;

   // FSM output decode
   logic sample_data;
   logic sample_parity;
   logic sample_stop;
   logic frame_done;
   logic stop_fail;
   logic parity_fail;
   logic word_ok;
   logic push;
   logic push_ready;
   logic frame_evt;
   logic parity_evt;
   logic overflow_evt;

   // START samples at mid-bit; every later bit is sampled one full bit
   // period after the previous sample, which keeps all samples mid-bit.
   always_comb begin
      if (state_reg == ST_START) begin
         bit_tick = (cnt_reg == CNT_W'(HALF - 1));
      end else begin
         bit_tick = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
      end
   end

   assign last_data = (bit_idx_reg == IDX_W'(PKT_W - 1));
   assign last_stop = (bit_idx_reg == IDX_W'(STOP_BITS - 1));
   assign data_pos  = (MSB_FIRST != 0) ? (IDX_W'(PKT_W - 1) - bit_idx_reg) : bit_idx_reg;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_edge) begin
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               // A start bit that is high again at mid-bit was a glitch.
               state_next = line_cur ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick && last_data) begin
               state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick && last_stop) begin
               state_next = (stop_bad_reg | ~line_cur) ? ST_WAIT_IDLE : ST_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            // A broken frame may leave the line low; re-arm only once it
            // has returned high so the tail is not taken as a new start.
            if (line_cur) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      sample_data   = 1'b0;
      sample_parity = 1'b0;
      sample_stop   = 1'b0;
      frame_done    = 1'b0;
      case (state_reg)
         ST_DATA:   sample_data   = bit_tick;
         ST_PARITY: sample_parity = bit_tick;
         ST_STOP: begin
            sample_stop = bit_tick;
            frame_done  = bit_tick & last_stop;
         end
         default: ;
      endcase

      stop_fail   = stop_bad_reg | ~line_cur;
      parity_fail = (PARITY != PARITY_NONE) &&
                    !parity_ok(^shift_reg, parity_bit_reg, PARITY);

      // Stop failure takes precedence, then parity, then FIFO space.
      frame_evt    = frame_done & stop_fail;
      parity_evt   = frame_done & ~stop_fail & parity_fail;
      word_ok      = frame_done & ~stop_fail & ~parity_fail;
      push         = word_ok & push_ready;
      overflow_evt = word_ok & ~push_ready;
   end

   // Bit counter, bit index, parity and stop-bit tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         parity_bit_reg <= 1'b0;
         stop_bad_reg   <= 1'b0;
      end else begin
         if ((state_next != state_reg) || bit_tick ||
             (state_reg == ST_IDLE) || (state_reg == ST_WAIT_IDLE)) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end

         if (state_next != state_reg) begin
            bit_idx_reg <= '0;
         end else if (sample_data || sample_stop) begin
            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
         end

         if (sample_parity) begin
            parity_bit_reg <= line_cur;
         end

         if ((state_reg == ST_IDLE) && start_edge) begin
            stop_bad_reg <= 1'b0;
         end else if (sample_stop && !line_cur) begin
            stop_bad_reg <= 1'b1;
         end
      end
   end

   // Shift register: each data sample lands directly at its final bit
   // position, so both bit orders share one structure.
   generate
      for (genvar gi = 0; gi < PKT_W; gi++) begin : g_shift
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               shift_reg[gi] <= 1'b0;
            end else if (sample_data && (data_pos == IDX_W'(gi))) begin
               shift_reg[gi] <= line_cur;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Sticky error flags: a same-cycle event wins over io_clrErr.
   // ---------------------------------------------------------------------
   logic frame_err_reg;
   logic parity_err_reg;
   logic overflow_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         frame_err_reg  <= frame_evt    | (frame_err_reg  & ~io_clrErr);
         parity_err_reg <= parity_evt   | (parity_err_reg & ~io_clrErr);
         overflow_reg   <= overflow_evt | (overflow_reg   & ~io_clrErr);
      end
   end

   // ---------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------
   logic fifo_empty;

   sync_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clock),
      .rst        (reset),
      .push       (push),
      .wr_data    (shift_reg),
      .pop        (io_rdEn),
      .rd_data    (io_pOut),
      .rd_valid   (io_validOut),
      .push_ready (push_ready),
      .empty      (fifo_empty),
      .count      (io_count)
   );

   assign io_dataReady = ~fifo_empty;
   assign io_frameErr  = frame_err_reg;
   assign io_parityErr = parity_err_reg;
   assign io_overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_serial_rx_fifo
// Drives serial frames into two builds of serial_rx_fifo (default framing,
// and even parity with LSB-first order) and compares every observable output
// against a queue-based model of the receiver's frame-level rules.
// ----------------------------------------------------------------------------
module tb_serial_rx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       line_val;
   logic       use_p;
   logic       rd_en;
   logic       clr_err;

   always #5 clock = ~clock;

   // Build A: PARITY=0, MSB_FIRST=1.  Build B: PARITY=1 (even), MSB_FIRST=0.
   logic       sin_a, sin_b, rd_a, rd_b, clr_a, clr_b;
   logic       ready_a, ready_b, valid_a, valid_b;
   logic [7:0] pout_a, pout_b;
   logic [2:0] count_a, count_b;
   logic       ferr_a, ferr_b, perr_a, perr_b, ovf_a, ovf_b;

   assign sin_a = use_p ? 1'b1 : line_val;
   assign sin_b = use_p ? line_val : 1'b1;
   assign rd_a  = rd_en & ~use_p;
   assign rd_b  = rd_en & use_p;
   assign clr_a = clr_err & ~use_p;
   assign clr_b = clr_err & use_p;

   serial_rx_fifo #(
      .PKT_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1),
      .MSB_FIRST(1), .FIFO_DEPTH(DEPTH)
   ) dut_a (
      .clock(clock), .reset(reset), .io_sIn(sin_a), .io_rdEn(rd_a),
      .io_clrErr(clr_a), .io_dataReady(ready_a), .io_pOut(pout_a),
      .io_validOut(valid_a), .io_count(count_a), .io_frameErr(ferr_a),
      .io_parityErr(perr_a), .io_overflow(ovf_a)
   );

   serial_rx_fifo #(
      .PKT_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1),
      .MSB_FIRST(0), .FIFO_DEPTH(DEPTH)
   ) dut_b (
      .clock(clock), .reset(reset), .io_sIn(sin_b), .io_rdEn(rd_b),
      .io_clrErr(clr_b), .io_dataReady(ready_b), .io_pOut(pout_b),
      .io_validOut(valid_b), .io_count(count_b), .io_frameErr(ferr_b),
      .io_parityErr(perr_b), .io_overflow(ovf_b)
   );

   // Outputs of the build currently under test
   logic       o_ready, o_valid, o_ferr, o_perr, o_ovf;
   logic [7:0] o_pout;
   logic [2:0] o_count;

   assign o_ready = use_p ? ready_b : ready_a;
   assign o_valid = use_p ? valid_b : valid_a;
   assign o_pout  = use_p ? pout_b  : pout_a;
   assign o_count = use_p ? count_b : count_a;
   assign o_ferr  = use_p ? ferr_b  : ferr_a;
   assign o_perr  = use_p ? perr_b  : perr_a;
   assign o_ovf   = use_p ? ovf_b   : ovf_a;

   // Reference model
   logic [7:0] model_q[$];
   bit         m_frame, m_parity, m_ovf;
   logic [7:0] m_last_pout;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      line_val = b;
      repeat (CPB) @(negedge clock);
   endtask

   // par_kind: 0 no parity bit, 1 correct even parity, 2 wrong parity.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int par_kind);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(use_p ? d[i] : d[7-i]);
      end
      if (par_kind == 1) drive_bit(^d);
      else if (par_kind == 2) drive_bit(~^d);
      if (stop_ok) begin
         drive_bit(1'b1);
      end else begin
         drive_bit(1'b0);
         drive_bit(1'b0);
         drive_bit(1'b0);
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      if (!stop_ok)                     m_frame = 1'b1;
      else if (par_kind == 2)           m_parity = 1'b1;
      else if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else                              model_q.push_back(d);
      $display("frame d=%02h stop_ok=%0d par=%0d queued=%0d", d, stop_ok, par_kind, model_q.size());
   endtask

   task automatic check_status(input string tag);
      check({tag, ".ready"},  o_ready, model_q.size() != 0);
      check({tag, ".count"},  o_count, model_q.size());
      check({tag, ".frame"},  o_ferr,  m_frame);
      check({tag, ".parity"}, o_perr,  m_parity);
      check({tag, ".ovf"},    o_ovf,   m_ovf);
   endtask

   task automatic read_one(input string tag);
      logic [7:0] exp;
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      if (model_q.size() != 0) begin
         exp = model_q.pop_front();
         m_last_pout = exp;
         check({tag, ".valid"}, o_valid, 1'b1);
         check({tag, ".pout"},  o_pout,  exp);
      end else begin
         check({tag, ".valid_empty"}, o_valid, 1'b0);
         check({tag, ".pout_hold"},   o_pout,  m_last_pout);
      end
      $display("read %s valid=%0d pout=%02h", tag, o_valid, o_pout);
      @(negedge clock);
      check({tag, ".valid_drop"}, o_valid, 1'b0);
   endtask

   task automatic clear_flags();
      clr_err = 1'b1;
      @(negedge clock);
      clr_err = 1'b0;
      m_frame = 0; m_parity = 0; m_ovf = 0;
      $display("clear flags");
   endtask

   initial begin
      logic [7:0] pat;
      reset = 1'b1; line_val = 1'b1; use_p = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      m_frame = 0; m_parity = 0; m_ovf = 0; m_last_pout = 8'h00;
      repeat (3) @(negedge clock);
      check_status("reset");
      check("reset.pout", o_pout, 8'h00);
      check("reset.valid", o_valid, 1'b0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // 1: single word
      send_frame(8'hA5, 1'b1, 0);
      check_status("t1");
      read_one("t1");
      check_status("t1_after");

      // 2: overflow
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
      check_status("t2");
      for (int i = 0; i < 4; i++) read_one("t2");
      check_status("t2_drained");

      // 3: frame error then good word
      send_frame(8'h3C, 1'b0, 0);
      send_frame(8'h5A, 1'b1, 0);
      check_status("t3");

      // 4: one-cycle glitch on idle line
      line_val = 1'b0;
      @(negedge clock);
      line_val = 1'b1;
      repeat (12) @(negedge clock);
      check_status("t4");

      // 6: reset during data bit 3, flags and one word pending
      pat = 8'h96;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(pat[7-i]);
      line_val = pat[4];
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      line_val = 1'b1;
      #1;
      model_q.delete(); m_frame = 0; m_parity = 0; m_ovf = 0; m_last_pout = 8'h00;
      check_status("t6_rst");
      check("t6_rst.pout", o_pout, 8'h00);
      check("t6_rst.valid", o_valid, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check_status("t6_rel");
      send_frame(8'h81, 1'b1, 0);
      read_one("t6");
      read_one("t6_empty");

      // Randomized frames with interleaved reads and clears on build A
      for (int n = 0; n < 24; n++) begin
         send_frame(8'($urandom), $urandom_range(0, 7) != 0, 0);
         for (int r = $urandom_range(0, 2); r > 0; r--) read_one("rnd");
         if ($urandom_range(0, 4) == 0) clear_flags();
         check_status("rnd");
      end

      // 5: parity build
      use_p = 1'b1;
      model_q.delete(); m_frame = 0; m_parity = 0; m_ovf = 0; m_last_pout = 8'h00;
      repeat (4) @(negedge clock);
      send_frame(8'h07, 1'b1, 2);
      check_status("t5_bad");
      send_frame(8'h07, 1'b1, 1);
      check_status("t5_good");
      read_one("t5");
      clear_flags();
      check_status("t5_clr");
      for (int n = 0; n < 10; n++) begin
         send_frame(8'($urandom), 1'b1, $urandom_range(1, 3) == 3 ? 2 : 1);
         read_one("rndp");
         check_status("rndp");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
